// File: rtl/sma_in_conditioner_pkg.sv
// Shared definitions for the SMA/PIO input conditioners.
package sma_in_conditioner_pkg;

    localparam int unsigned SMA_SYNC_STAGES   = 2;
    localparam int unsigned SMA_FILTER_CYCLES = 4;

    typedef enum logic [0:0] {
        ST_WAIT_FIRST = 1'b0,
        ST_MEASURE    = 1'b1
    } period_state_e;

endpackage

// File: rtl/sma_sync_filter.sv
// Synchroniser, glitch filter and registered edge pulses for one async input.
module sma_sync_filter
    import sma_in_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SMA_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = SMA_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sma_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sma_in};
        end
    end

    // Filter: level follows s only after FILTER_CYCLES consecutive differing samples
    always_comb begin
        fcnt_d  = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (fcnt_q == FCNT_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state and edge pulses, registered together so pulses align with level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/sma_in_conditioner.sv
// SMA input conditioner: filtered level, edge pulses, rise counter and period meter.
module sma_in_conditioner
    import sma_in_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SMA_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = SMA_FILTER_CYCLES,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sma_in,
    input  logic             clr_cnt,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             overflow,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    period_state_e    state_q, state_d;

    sma_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .sma_in     (sma_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Saturating rise counter; a clear still counts a rise arriving with it
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        overflow_d = overflow_q;
        if (clr_cnt) begin
            edge_cnt_d = rise_pulse ? CNT_W'(1) : '0;
            overflow_d = 1'b0;
        end else if (rise_pulse) begin
            if (edge_cnt_q == CNT_ONES) begin
                overflow_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    // Period FSM: timer restarts at 1 on each rise so rises N apart read back N
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        valid_d  = valid_q;
        timer_d  = (timer_q == CNT_ONES) ? timer_q : timer_q + 1'b1;
        if (rise_pulse) begin
            timer_d = CNT_W'(1);
        end
        if (clr_cnt) begin
            period_d = '0;
            valid_d  = 1'b0;
            state_d  = rise_pulse ? ST_MEASURE : ST_WAIT_FIRST;
        end else begin
            case (state_q)
                ST_WAIT_FIRST: begin
                    if (rise_pulse) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_pulse) begin
                        period_d = timer_q;
                        valid_d  = 1'b1;
                    end else if (timer_q == CNT_ONES) begin
                        // Signal lost: keep the last period but flag it stale
                        valid_d = 1'b0;
                        state_d = ST_WAIT_FIRST;
                    end
                end
                default: state_d = ST_WAIT_FIRST;
            endcase
        end
    end

    // Counter, timer and FSM state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_q <= '0;
            overflow_q <= 1'b0;
            timer_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            state_q    <= ST_WAIT_FIRST;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            overflow_q <= overflow_d;
            timer_q    <= timer_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
        end
    end

    assign edge_cnt     = edge_cnt_q;
    assign overflow     = overflow_q;
    assign period       = period_q;
    assign period_valid = valid_q;

endmodule

// File: tb/tb_sma_in_conditioner.sv
// Directed bench: DUT A uses defaults, DUT B uses CNT_W=4 and FILTER_CYCLES=2.
module tb_sma_in_conditioner;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sma_in = 1'b0;
    logic clr_cnt = 1'b0;

    logic        a_level_out, a_rise_pulse, a_fall_pulse, a_overflow, a_period_valid;
    logic [15:0] a_edge_cnt, a_period;
    logic        b_level_out, b_rise_pulse, b_fall_pulse, b_overflow, b_period_valid;
    logic [3:0]  b_edge_cnt, b_period;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int a_rises = 0;
    int a_falls = 0;
    int b_rises = 0;
    int b_last_rise = 0;
    int both_high = 0;
    logic a_rise_prev = 1'b0;
    logic a_valid_after [8];

    typedef struct {
        int width;
        int exp_rises;
        int exp_cnt;
    } glitch_vec_t;

    glitch_vec_t vecs [7];

    always #5 clk = ~clk;

    sma_in_conditioner u_dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .sma_in       (sma_in),
        .clr_cnt      (clr_cnt),
        .level_out    (a_level_out),
        .rise_pulse   (a_rise_pulse),
        .fall_pulse   (a_fall_pulse),
        .edge_cnt     (a_edge_cnt),
        .overflow     (a_overflow),
        .period       (a_period),
        .period_valid (a_period_valid)
    );

    sma_in_conditioner #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (2),
        .CNT_W         (4)
    ) u_dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .sma_in       (sma_in),
        .clr_cnt      (clr_cnt),
        .level_out    (b_level_out),
        .rise_pulse   (b_rise_pulse),
        .fall_pulse   (b_fall_pulse),
        .edge_cnt     (b_edge_cnt),
        .overflow     (b_overflow),
        .period       (b_period),
        .period_valid (b_period_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge and keep pulse bookkeeping
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (a_rise_prev && a_rises >= 1 && a_rises <= 8) a_valid_after[a_rises-1] = a_period_valid;
        if (a_rise_pulse) a_rises++;
        if (a_fall_pulse) a_falls++;
        a_rise_prev = a_rise_pulse;
        if (b_rise_pulse) begin
            b_rises++;
            b_last_rise = cyc;
        end
        if ((a_rise_pulse && a_fall_pulse) || (b_rise_pulse && b_fall_pulse)) both_high++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;

        // width (synced high cycles), rises expected, cumulative edge_cnt of DUT A
        vecs[0] = '{1, 0, 0};
        vecs[1] = '{2, 0, 0};
        vecs[2] = '{3, 0, 0};
        vecs[3] = '{4, 1, 1};
        vecs[4] = '{6, 1, 2};
        vecs[5] = '{3, 0, 2};
        vecs[6] = '{10, 1, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset a_level_out", 32'(a_level_out), 0);
        chk("reset a_edge_cnt", 32'(a_edge_cnt), 0);
        chk("reset b_period_valid", 32'(b_period_valid), 0);
        reset_n = 1'b1;
        repeat (3) cycle();

        // Glitch filter table on DUT A
        for (int i = 0; i < 7; i++) begin
            a_rises = 0;
            a_falls = 0;
            sma_in = 1'b1;
            repeat (vecs[i].width) cycle();
            sma_in = 1'b0;
            repeat (14) cycle();
            chk($sformatf("vec%0d rises", i), 32'(a_rises), 32'(vecs[i].exp_rises));
            chk($sformatf("vec%0d falls", i), 32'(a_falls), 32'(vecs[i].exp_rises));
            chk($sformatf("vec%0d edge_cnt", i), 32'(a_edge_cnt), 32'(vecs[i].exp_cnt));
        end

        // Clean step: 2 sync + 4 filter clocks
        sma_in = 1'b1;
        k = 0;
        while (!a_level_out && k < 20) begin
            cycle();
            k++;
        end
        chk("rise latency", 32'(k), 6);
        chk("rise_pulse on level change", 32'(a_rise_pulse), 1);
        cycle();
        chk("rise_pulse one cycle", 32'(a_rise_pulse), 0);
        repeat (2) cycle();
        sma_in = 1'b0;
        k = 0;
        while (a_level_out && k < 20) begin
            cycle();
            k++;
        end
        chk("fall latency", 32'(k), 6);
        chk("fall_pulse on level change", 32'(a_fall_pulse), 1);
        repeat (4) cycle();

        // Period: five rises 10 clocks apart
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        a_rises = 0;
        for (int i = 0; i < 5; i++) begin
            sma_in = 1'b1;
            repeat (5) cycle();
            sma_in = 1'b0;
            repeat (5) cycle();
        end
        repeat (8) cycle();
        chk("period rises", 32'(a_rises), 5);
        chk("period edge_cnt", 32'(a_edge_cnt), 5);
        chk("period value", 32'(a_period), 10);
        chk("valid after 1st rise", 32'(a_valid_after[0]), 0);
        chk("valid after 2nd rise", 32'(a_valid_after[1]), 1);
        chk("period_valid held", 32'(a_period_valid), 1);

        // Saturation on DUT B: 17 rises 5 clocks apart
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        b_rises = 0;
        for (int i = 0; i < 17; i++) begin
            sma_in = 1'b1;
            repeat (3) cycle();
            sma_in = 1'b0;
            repeat (2) cycle();
        end
        chk("sat rises", 32'(b_rises), 17);
        chk("sat edge_cnt", 32'(b_edge_cnt), 15);
        chk("sat overflow", 32'(b_overflow), 1);
        chk("sat period", 32'(b_period), 5);
        chk("sat period_valid", 32'(b_period_valid), 1);

        // Signal lost: timer is 1 the cycle after the pulse, 15 fourteen cycles later,
        // so valid reads 0 sixteen cycles after the last pulse
        k = 0;
        while (b_period_valid && k < 40) begin
            cycle();
            k++;
        end
        chk("timeout cycles", 32'(cyc - b_last_rise), 16);
        chk("timeout period kept", 32'(b_period), 5);

        // First rise after timeout only arms the FSM
        sma_in = 1'b1;
        repeat (3) cycle();
        sma_in = 1'b0;
        repeat (10) cycle();
        chk("wait_first valid", 32'(b_period_valid), 0);
        chk("wait_first period", 32'(b_period), 5);
        chk("wait_first overflow", 32'(b_overflow), 1);

        // clr_cnt together with rise_pulse, then a rise 8 clocks later
        sma_in = 1'b1;
        k = 0;
        while (!b_rise_pulse && k < 12) begin
            cycle();
            k++;
        end
        chk("clr rise latency", 32'(k), 4);
        r = cyc;
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        sma_in = 1'b0;
        chk("clr+rise edge_cnt", 32'(b_edge_cnt), 1);
        chk("clr+rise overflow", 32'(b_overflow), 0);
        chk("clr+rise period_valid", 32'(b_period_valid), 0);
        chk("clr+rise period", 32'(b_period), 0);
        repeat (3) cycle();
        sma_in = 1'b1;
        k = 0;
        while (!b_rise_pulse && k < 12) begin
            cycle();
            k++;
        end
        chk("clr next rise gap", 32'(cyc - r), 8);
        cycle();
        chk("clr next period", 32'(b_period), 8);
        chk("clr next period_valid", 32'(b_period_valid), 1);
        chk("clr next edge_cnt", 32'(b_edge_cnt), 2);

        // Asynchronous reset mid-stream, between clock edges
        repeat (8) cycle();
        chk("pre-reset a_level_out", 32'(a_level_out), 1);
        repeat (2) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset a_level_out", 32'(a_level_out), 0);
        chk("async reset a_edge_cnt", 32'(a_edge_cnt), 0);
        chk("async reset b_edge_cnt", 32'(b_edge_cnt), 0);
        chk("async reset b_period", 32'(b_period), 0);
        chk("async reset b_period_valid", 32'(b_period_valid), 0);
        sma_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) cycle();

        chk("rise and fall never together", 32'(both_high), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
